// File: rtl/partita_pkg.sv
// Shared types for the rock-paper-scissors match controller.
// Move, round-result, match-result and FSM state encodings.
package partita_pkg;

   typedef enum logic [1:0] {
      NESSUNA = 2'b00,
      SASSO   = 2'b01,
      CARTA   = 2'b10,
      FORBICE = 2'b11
   } mossa_t;

   typedef enum logic [1:0] {
      M_NULLA   = 2'b00,
      M_PRIMO   = 2'b01,
      M_SECONDO = 2'b10,
      M_PARI    = 2'b11
   } manche_t;

   typedef enum logic [1:0] {
      P_CORSO   = 2'b00,
      P_PRIMO   = 2'b01,
      P_SECONDO = 2'b10,
      P_PARI    = 2'b11
   } partita_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GIOCO = 2'b01,
      FINE  = 2'b10
   } stato_t;

   function automatic logic batte(input mossa_t a, input mossa_t b);
      return (a == CARTA && b == SASSO) || (a == SASSO && b == FORBICE) ||
             (a == FORBICE && b == CARTA);
   endfunction

endpackage

// File: rtl/manche_arbitro.sv
// Combinational round referee: validates a pair of moves against the
// repeat rule and decides the round winner.
module manche_arbitro
   import partita_pkg::*;
(
   input  mossa_t  primo,
   input  mossa_t  secondo,
   input  manche_t ultimo,
   input  mossa_t  mossa_ult,
   input  logic    no_repeat,
   output logic    valida,
   output manche_t esito
);

   always_comb begin
      valida = 1'b1;
      esito  = M_NULLA;
      if (primo == NESSUNA || secondo == NESSUNA)
         valida = 1'b0;
      else if (no_repeat &&
               ((ultimo == M_PRIMO   && primo   == mossa_ult) ||
                (ultimo == M_SECONDO && secondo == mossa_ult)))
         valida = 1'b0;

      if (valida) begin
         if (primo == secondo)
            esito = M_PARI;
         else if (batte(primo, secondo))
            esito = M_PRIMO;
         else
            esito = M_SECONDO;
      end
   end

endmodule

// File: rtl/partita_param.sv
// Match controller: counts rounds and scores, ends on lead after
// MIN_MANCHE or unconditionally at MAX_MANCHE. All outputs registered.
module partita_param
   import partita_pkg::*;
#(
   parameter int MIN_MANCHE = 4,
   parameter int MAX_MANCHE = 19,
   parameter int SCARTO     = 2,
   parameter int NO_REPEAT  = 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            INIZIA,
   input  logic [1:0]                      PRIMO,
   input  logic [1:0]                      SECONDO,
   output logic [1:0]                      MANCHE,
   output logic [1:0]                      PARTITA,
   output logic [$clog2(MAX_MANCHE+1)-1:0] N_MANCHE
);

   localparam int W = $clog2(MAX_MANCHE + 1);
   localparam logic [W-1:0] UNO = W'(1);

   if (MIN_MANCHE > MAX_MANCHE || MAX_MANCHE < 1 || SCARTO < 1) begin : g_param_err
      $error("partita_param: illegal MIN_MANCHE/MAX_MANCHE/SCARTO combination");
   end

   stato_t   stato_q, stato_n;
   manche_t  manche_q, manche_n, ultimo_q, ultimo_n, esito;
   partita_t partita_q, partita_n;
   mossa_t   mossa_q, mossa_n;
   logic [W-1:0] s1_q, s1_n, s2_q, s2_n, n_q, n_n, diff;
   logic     valida;

   manche_arbitro u_arbitro (
      .primo     (mossa_t'(PRIMO)),
      .secondo   (mossa_t'(SECONDO)),
      .ultimo    (ultimo_q),
      .mossa_ult (mossa_q),
      .no_repeat (NO_REPEAT != 0),
      .valida    (valida),
      .esito     (esito)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stato_q   <= IDLE;
         manche_q  <= M_NULLA;
         partita_q <= P_CORSO;
         ultimo_q  <= M_NULLA;
         mossa_q   <= NESSUNA;
         s1_q      <= '0;
         s2_q      <= '0;
         n_q       <= '0;
      end else begin
         stato_q   <= stato_n;
         manche_q  <= manche_n;
         partita_q <= partita_n;
         ultimo_q  <= ultimo_n;
         mossa_q   <= mossa_n;
         s1_q      <= s1_n;
         s2_q      <= s2_n;
         n_q       <= n_n;
      end
   end

   always_comb begin
      stato_n   = stato_q;
      manche_n  = M_NULLA;
      partita_n = partita_q;
      ultimo_n  = ultimo_q;
      mossa_n   = mossa_q;
      s1_n      = s1_q;
      s2_n      = s2_q;
      n_n       = n_q;
      diff      = '0;

      if (INIZIA) begin
         stato_n   = GIOCO;
         partita_n = P_CORSO;
         ultimo_n  = M_NULLA;
         mossa_n   = NESSUNA;
         s1_n      = '0;
         s2_n      = '0;
         n_n       = '0;
      end else if (stato_q == GIOCO && valida) begin
         manche_n = esito;
         n_n      = n_q + UNO;
         case (esito)
            M_PRIMO: begin
               s1_n     = s1_q + UNO;
               ultimo_n = M_PRIMO;
               mossa_n  = mossa_t'(PRIMO);
            end
            M_SECONDO: begin
               s2_n     = s2_q + UNO;
               ultimo_n = M_SECONDO;
               mossa_n  = mossa_t'(SECONDO);
            end
            default: begin
               ultimo_n = M_NULLA;
               mossa_n  = NESSUNA;
            end
         endcase

         // End-of-match decision uses the post-round score and count
         diff = (s1_n > s2_n) ? (s1_n - s2_n) : (s2_n - s1_n);
         if (32'(n_n) >= MIN_MANCHE && 32'(diff) >= SCARTO) begin
            stato_n   = FINE;
            partita_n = (s1_n > s2_n) ? P_PRIMO : P_SECONDO;
         end else if (32'(n_n) == MAX_MANCHE) begin
            stato_n   = FINE;
            partita_n = (s1_n > s2_n) ? P_PRIMO :
                        (s2_n > s1_n) ? P_SECONDO : P_PARI;
         end
      end
   end

   assign MANCHE   = manche_q;
   assign PARTITA  = partita_q;
   assign N_MANCHE = n_q;

endmodule

// File: tb/tb_partita_param.sv
// Directed self-checking bench for partita_param (default parameters,
// plus a NO_REPEAT=0 instance sharing the same stimulus).
module tb_partita_param;

   logic       clk;
   logic       rst_n;
   logic       INIZIA;
   logic [1:0] PRIMO, SECONDO;
   logic [1:0] MANCHE, PARTITA, MANCHE2, PARTITA2;
   logic [4:0] N_MANCHE, N_MANCHE2;

   int vectors = 0;
   int miscompares = 0;

   partita_param dut (
      .clk(clk), .rst_n(rst_n), .INIZIA(INIZIA), .PRIMO(PRIMO), .SECONDO(SECONDO),
      .MANCHE(MANCHE), .PARTITA(PARTITA), .N_MANCHE(N_MANCHE)
   );

   partita_param #(.NO_REPEAT(0)) dut_nr (
      .clk(clk), .rst_n(rst_n), .INIZIA(INIZIA), .PRIMO(PRIMO), .SECONDO(SECONDO),
      .MANCHE(MANCHE2), .PARTITA(PARTITA2), .N_MANCHE(N_MANCHE2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic outs(input string tag, input int em, input int ep, input int en);
      check({tag, ".MANCHE"},   int'(MANCHE),   em);
      check({tag, ".PARTITA"},  int'(PARTITA),  ep);
      check({tag, ".N_MANCHE"}, int'(N_MANCHE), en);
   endtask

   task automatic step(input string tag, input logic ini, input logic [1:0] p,
                       input logic [1:0] s, input int em, input int ep, input int en);
      INIZIA  = ini;
      PRIMO   = p;
      SECONDO = s;
      @(posedge clk);
      #1;
      outs(tag, em, ep, en);
   endtask

   initial begin
      rst_n = 1'b0; INIZIA = 1'b0; PRIMO = 2'b00; SECONDO = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      outs("reset", 0, 0, 0);
      rst_n = 1'b1;

      step("idle",  1'b0, 2'b01, 2'b10, 0, 0, 0);
      step("start", 1'b1, 2'b01, 2'b11, 0, 0, 0);

      // lead reached early but match only closes at round 4
      step("r1", 1'b0, 2'b01, 2'b11, 1, 0, 1);
      step("r2", 1'b0, 2'b10, 2'b01, 1, 0, 2);
      step("r3", 1'b0, 2'b11, 2'b10, 1, 0, 3);
      step("r4", 1'b0, 2'b01, 2'b11, 1, 1, 4);
      step("fine_hold", 1'b0, 2'b01, 2'b10, 0, 1, 4);

      step("restart_fine", 1'b1, 2'b10, 2'b01, 0, 0, 0);
      step("after_restart", 1'b0, 2'b10, 2'b01, 1, 0, 1);

      // primo repeats carta: rejected with NO_REPEAT=1, counted otherwise
      step("repeat_primo", 1'b0, 2'b10, 2'b01, 0, 0, 1);
      check("norep.MANCHE",   int'(MANCHE2),   1);
      check("norep.N_MANCHE", int'(N_MANCHE2), 2);

      step("none_move", 1'b0, 2'b00, 2'b01, 0, 0, 1);
      step("draw",      1'b0, 2'b11, 2'b11, 3, 0, 2);
      step("after_draw", 1'b0, 2'b10, 2'b01, 1, 0, 3);
      step("sec_win",   1'b0, 2'b01, 2'b10, 2, 0, 4);
      step("repeat_sec", 1'b0, 2'b11, 2'b10, 0, 0, 4);

      // asynchronous reset between edges
      #2 rst_n = 1'b0;
      #1;
      outs("async_rst", 0, 0, 0);
      check("async_rst.MANCHE2", int'(MANCHE2), 0);
      #2 rst_n = 1'b1;
      step("post_rst_idle", 1'b0, 2'b01, 2'b11, 0, 0, 0);

      // all draws until the round limit
      step("start_draws", 1'b1, 2'b00, 2'b00, 0, 0, 0);
      for (int i = 1; i <= 19; i++)
         step($sformatf("draw%0d", i), 1'b0, 2'b11, 2'b11, 3, (i == 19) ? 3 : 0, i);
      step("max_hold", 1'b0, 2'b01, 2'b10, 0, 3, 19);

      // secondo sweeps four rounds
      step("start_sec", 1'b1, 2'b00, 2'b00, 0, 0, 0);
      step("s1", 1'b0, 2'b11, 2'b01, 2, 0, 1);
      step("s2", 1'b0, 2'b01, 2'b10, 2, 0, 2);
      step("s3", 1'b0, 2'b10, 2'b11, 2, 0, 3);
      step("s4", 1'b0, 2'b11, 2'b01, 2, 2, 4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
